// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : Host-to-device PS/2 transmitter. Sends one command byte to
//                the keyboard over the shared open-collector clkps2/dataps2
//                pair: inhibit, request-to-send, 8 data bits + odd parity +
//                stop, then checks the device acknowledge.
//  Ports       : clk_chipset  - chipset clock, all logic on its rising edge
//                reset_n      - synchronous reset, active low
//                tx_data      - byte to send, taken when tx_valid & tx_ready
//                tx_valid     - send request (ignored while busy)
//                tx_ready     - 1 only while idle
//                tx_done      - 1-cycle pulse: byte acknowledged, bus idle
//                tx_error     - 1-cycle pulse: timeout / no ack, bus released
//                busy         - 1 whenever not idle
//                ps2_clk_in   - raw clkps2 pin level (asynchronous)
//                ps2_data_in  - raw dataps2 pin level (asynchronous)
//                ps2_clk_oe   - 1 = pull clkps2 low
//                ps2_data_oe  - 1 = pull dataps2 low
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int INHIBIT_US   = 120,
   parameter int START_TMO_US = 15000,
   parameter int XFER_TMO_US  = 2000,
   parameter int FILT_LEN     = 8
) (
   input  logic       clk_chipset,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int c_CYC_PER_US  = CLK_HZ / 1_000_000;
   localparam int c_INHIBIT_CYC = c_CYC_PER_US * INHIBIT_US;
   localparam int c_START_CYC   = c_CYC_PER_US * START_TMO_US;
   localparam int c_XFER_CYC    = c_CYC_PER_US * XFER_TMO_US;
   localparam int c_TMO_MAX0    = (c_START_CYC > c_XFER_CYC) ? c_START_CYC : c_XFER_CYC;
   localparam int c_TMO_MAX     = (c_TMO_MAX0 > c_INHIBIT_CYC) ? c_TMO_MAX0 : c_INHIBIT_CYC;
   localparam int c_TMO_W       = $clog2(c_TMO_MAX + 1);
   localparam int c_FILT_W      = $clog2(FILT_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INHIBIT  = 3'd1,
      S_REQ      = 3'd2,
      S_BITS     = 3'd3,
      S_ACK      = 3'd4,
      S_WAITIDLE = 3'd5,
      S_DONE     = 3'd6,
      S_FAIL     = 3'd7
   } state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_clk_s1, r_clk_s2, r_data_s1, r_data_s2;
   logic                 r_clk_filt, r_clk_filt_q;
   logic [c_FILT_W-1:0]  r_filt_cnt;
   logic [8:0]           r_shift, w_shift_nxt;
   logic                 r_drv, w_drv_nxt;
   logic [3:0]           r_bitcnt, w_bitcnt_nxt;
   logic [c_TMO_W-1:0]   r_tmo, r_xfer;
   logic                 w_fe, w_start_exp, w_xfer_exp, w_inh_last;

   // ------------------------------------------------------------------
   // Input conditioning: 2-flop synchronisers, clock glitch filter
   // ------------------------------------------------------------------
   always_ff @(posedge clk_chipset) begin
      if (!reset_n) begin
         r_clk_s1     <= 1'b1;
         r_clk_s2     <= 1'b1;
         r_data_s1    <= 1'b1;
         r_data_s2    <= 1'b1;
         r_clk_filt   <= 1'b1;
         r_clk_filt_q <= 1'b1;
         r_filt_cnt   <= '0;
      end else begin
         r_clk_s1     <= ps2_clk_in;
         r_clk_s2     <= r_clk_s1;
         r_data_s1    <= ps2_data_in;
         r_data_s2    <= r_data_s1;
         r_clk_filt_q <= r_clk_filt;
         // Any sample equal to the current filtered level restarts the run.
         if (r_clk_s2 != r_clk_filt) begin
            if (r_filt_cnt == c_FILT_W'(FILT_LEN - 1)) begin
               r_clk_filt <= r_clk_s2;
               r_filt_cnt <= '0;
            end else begin
               r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
            end
         end else begin
            r_filt_cnt <= '0;
         end
      end
   end

   assign w_fe        = r_clk_filt_q & ~r_clk_filt;
   assign w_start_exp = (r_tmo  == c_TMO_W'(c_START_CYC - 1));
   assign w_xfer_exp  = (r_xfer == c_TMO_W'(c_XFER_CYC - 1));
   assign w_inh_last  = (r_tmo  == c_TMO_W'(c_INHIBIT_CYC - 1));

   // ------------------------------------------------------------------
   // FSM state and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_chipset) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_drv    <= 1'b0;
         r_bitcnt <= '0;
         r_tmo    <= '0;
         r_xfer   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_shift  <= w_shift_nxt;
         r_drv    <= w_drv_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         // State timer restarts on every state change, saturates otherwise.
         if (w_state_nxt != r_state)
            r_tmo <= '0;
         else if (r_tmo != c_TMO_W'(c_TMO_MAX))
            r_tmo <= r_tmo + c_TMO_W'(1);
         // Transfer timer spans BITS/ACK/WAITIDLE, starting at the first edge.
         if (r_state == S_BITS || r_state == S_ACK || r_state == S_WAITIDLE)
            r_xfer <= r_xfer + c_TMO_W'(1);
         else
            r_xfer <= '0;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state. Timeouts are tested before fe so expiry wins.
   // Every fe shifts a 1 in behind the frame so the 10th edge drives the
   // stop bit (released line) without a special case.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_shift_nxt  = r_shift;
      w_drv_nxt    = r_drv;
      w_bitcnt_nxt = r_bitcnt;
      case (r_state)
         S_IDLE: begin
            w_drv_nxt    = 1'b0;
            w_bitcnt_nxt = '0;
            if (tx_valid) begin
               w_shift_nxt = {~^tx_data, tx_data};
               w_state_nxt = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (w_inh_last)
               w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (w_start_exp) begin
               w_state_nxt = S_FAIL;
            end else if (w_fe) begin
               w_drv_nxt    = ~r_shift[0];
               w_shift_nxt  = {1'b1, r_shift[8:1]};
               w_bitcnt_nxt = 4'd1;
               w_state_nxt  = S_BITS;
            end
         end
         S_BITS: begin
            if (w_xfer_exp) begin
               w_state_nxt = S_FAIL;
            end else if (w_fe) begin
               w_drv_nxt    = ~r_shift[0];
               w_shift_nxt  = {1'b1, r_shift[8:1]};
               w_bitcnt_nxt = r_bitcnt + 4'd1;
               if (r_bitcnt == 4'd9)
                  w_state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            if (w_xfer_exp) begin
               w_state_nxt = S_FAIL;
            end else if (w_fe) begin
               w_bitcnt_nxt = 4'd11;
               w_state_nxt  = r_data_s2 ? S_FAIL : S_WAITIDLE;
            end
         end
         S_WAITIDLE: begin
            if (w_xfer_exp)
               w_state_nxt = S_FAIL;
            else if (r_clk_filt && r_data_s2)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         S_FAIL: begin
            w_drv_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign tx_ready    = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign tx_done     = (r_state == S_DONE);
   assign tx_error    = (r_state == S_FAIL);
   assign ps2_clk_oe  = (r_state == S_INHIBIT);
   // Start bit goes out in the last inhibit cycle and is held through REQ.
   assign ps2_data_oe = ((r_state == S_INHIBIT) && w_inh_last) ||
                        (r_state == S_REQ) ||
                        (((r_state == S_BITS) || (r_state == S_ACK)) && r_drv);

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with a PS/2 device
//                model on a wired-AND bus and an expected-frame scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int CLK_HZ   = 1_000_000;   // 1 cycle = 1 us
   localparam int INH      = 120;
   localparam int START_T  = 15000;
   localparam int XFER_T   = 2000;
   localparam int HALF     = 40;          // 12.5 kHz device clock

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_done, tx_error, busy;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       bfm_clk, bfm_data;
   logic       clk_pin, data_pin;

   assign clk_pin  = bfm_clk  & ~ps2_clk_oe;
   assign data_pin = bfm_data & ~ps2_data_oe;

   ps2_host_tx #(
      .CLK_HZ       (CLK_HZ),
      .INHIBIT_US   (INH),
      .START_TMO_US (START_T),
      .XFER_TMO_US  (XFER_T),
      .FILT_LEN     (8)
   ) u_dut (
      .clk_chipset (clk),
      .reset_n     (reset_n),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_error    (tx_error),
      .busy        (busy),
      .ps2_clk_in  (clk_pin),
      .ps2_data_in (data_pin),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_done = 0, n_errp = 0, n_inh = 0, err_cyc = 0;
   logic prev_oe = 1'b0;
   logic [10:0] sb_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (tx_done)  n_done++;
      if (tx_error) begin n_errp++; err_cyc = cyc; end
      if (ps2_clk_oe && !prev_oe) n_inh++;
      prev_oe = ps2_clk_oe;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tmo_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic send(input logic [7:0] d);
      int t = 0;
      @(negedge clk);
      while (!tx_ready && t < 4000) begin @(negedge clk); t++; end
      if (!tx_ready) tmo_fail("send_ready");
      tx_data  = d;
      tx_valid = 1'b1;
      sb_q.push_back({1'b1, ~^d, d, 1'b0});
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_ready(input int bound);
      int t = 0;
      while (!tx_ready && t < bound) begin @(negedge clk); t++; end
      if (!tx_ready) tmo_fail("wait_ready");
   endtask

   // Device model: waits for the host inhibit, samples the start bit, then
   // clocks n_edges falling edges, sampling data late in each high phase.
   task automatic device(input int n_edges, input bit give_ack, input int glitch_edge,
                         output logic [10:0] smp, output int inh,
                         output int rel_cyc, output int fe_cyc);
      int t = 0;
      smp = '1; inh = 0; rel_cyc = 0; fe_cyc = 0;
      while (!ps2_clk_oe && t < 2000) begin @(negedge clk); t++; end
      if (!ps2_clk_oe) begin tmo_fail("inhibit_start"); return; end
      while (ps2_clk_oe && inh < 2000) begin @(negedge clk); inh++; end
      rel_cyc = cyc;
      repeat (30) @(negedge clk);
      smp[0] = data_pin;
      for (int k = 1; k <= n_edges; k++) begin
         bfm_clk = 1'b0;
         if (k == 1) fe_cyc = cyc;
         repeat (HALF) @(negedge clk);
         bfm_clk = 1'b1;
         if (k == glitch_edge) begin
            repeat (15) @(negedge clk);
            bfm_clk = 1'b0;
            repeat (3) @(negedge clk);
            bfm_clk = 1'b1;
            repeat (20) @(negedge clk);
         end else begin
            repeat (HALF - 2) @(negedge clk);
         end
         if (k <= 10) smp[k] = data_pin;
         if (k == 10 && give_ack) bfm_data = 1'b0;
         repeat (2) @(negedge clk);
      end
      bfm_data = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      int         edges;
      bit         ack;
      int         glitch;
      bit         exp_done;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [10:0] smp, exp_f;
      int inh, rel, fe, d0, e0, i0;

      vecs[0] = '{8'hED, 11, 1'b1, 0, 1'b1};
      vecs[1] = '{8'h00, 11, 1'b1, 0, 1'b1};
      vecs[2] = '{8'hFF, 11, 1'b1, 0, 1'b1};
      vecs[3] = '{8'h01, 11, 1'b1, 0, 1'b1};
      vecs[4] = '{8'h5A, 11, 1'b0, 0, 1'b0};   // no ack
      vecs[5] = '{8'h3C, 11, 1'b1, 5, 1'b1};   // clock glitch after edge 5

      reset_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      bfm_clk = 1'b1; bfm_data = 1'b1;
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx_done", tx_done, 0);
      chk("rst_tx_error", tx_error, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         d0 = n_done; e0 = n_errp;
         send(vecs[i].data);
         device(vecs[i].edges, vecs[i].ack, vecs[i].glitch, smp, inh, rel, fe);
         exp_f = sb_q.pop_front();
         chk($sformatf("frame_%0d", i), smp, exp_f);
         chk_rng($sformatf("inhibit_%0d", i), inh, INH, INH + 2);
         wait_ready(4000);
         chk($sformatf("done_%0d", i), n_done - d0, vecs[i].exp_done ? 1 : 0);
         chk($sformatf("error_%0d", i), n_errp - e0, vecs[i].exp_done ? 0 : 1);
         chk($sformatf("oe_idle_%0d", i), {ps2_clk_oe, ps2_data_oe}, 0);
      end

      // Device never clocks: start timeout measured from clock release
      d0 = n_done; e0 = n_errp;
      send(8'hF0);
      device(0, 1'b0, 0, smp, inh, rel, fe);
      exp_f = sb_q.pop_front();
      chk("nostart_startbit", smp[0], exp_f[0]);
      wait_ready(START_T + 1000);
      chk("nostart_error", n_errp - e0, 1);
      chk("nostart_done", n_done - d0, 0);
      chk_rng("nostart_time", err_cyc - rel, START_T - 1, START_T + 1);
      chk("nostart_oe", {ps2_clk_oe, ps2_data_oe}, 0);

      // Device stops after edge 5: transfer timeout from the first edge
      d0 = n_done; e0 = n_errp;
      send(8'hA5);
      device(5, 1'b0, 0, smp, inh, rel, fe);
      exp_f = sb_q.pop_front();
      chk("stall_partial", smp[4:0], exp_f[4:0]);
      wait_ready(XFER_T + 1000);
      chk("stall_error", n_errp - e0, 1);
      chk("stall_done", n_done - d0, 0);
      chk_rng("stall_time", err_cyc - fe, XFER_T, XFER_T + 20);

      // Reset mid-frame after edge 4, then a clean 0xF4
      d0 = n_done; e0 = n_errp;
      send(8'h55);
      device(4, 1'b0, 0, smp, inh, rel, fe);
      void'(sb_q.pop_front());
      chk("rst_mid_data_oe_before", ps2_data_oe, 1);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready", tx_ready, 1);
      chk("rst_mid_pulses", (n_done - d0) + (n_errp - e0), 0);
      d0 = n_done;
      send(8'hF4);
      device(11, 1'b1, 0, smp, inh, rel, fe);
      exp_f = sb_q.pop_front();
      chk("after_rst_frame", smp, exp_f);
      wait_ready(4000);
      chk("after_rst_done", n_done - d0, 1);

      // tx_valid while busy is dropped; exactly one frame goes out
      d0 = n_done; i0 = n_inh;
      send(8'h96);
      fork
         device(11, 1'b1, 0, smp, inh, rel, fe);
         begin
            repeat (300) @(negedge clk);
            tx_data  = 8'hAA;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
         end
      join
      exp_f = sb_q.pop_front();
      chk("busy_frame", smp, exp_f);
      wait_ready(4000);
      repeat (300) @(negedge clk);
      chk("busy_done", n_done - d0, 1);
      chk("busy_one_frame", n_inh - i0, 1);
      chk("busy_idle", tx_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
